// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - instruction constants and encodings for the PC redirect controller
package pc_redirect_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_JR_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NPC_NONE   = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_RS     = 2'd3
    } npc_sel_e;

endpackage

// File: rtl/pc_redirect_decode.sv
// rtl/pc_redirect_decode.sv - classifies the ID instruction as J/JAL/JR and forms the J-type target
module pc_redirect_decode
    import pc_redirect_ctrl_pkg::*;
(
    input  logic        id_valid,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [25:0] instr_addr,
    input  logic [3:0]  pc_hi,
    output logic        is_j,
    output logic        is_jal,
    output logic        is_jr,
    output logic [31:0] jump_target
);

    always_comb begin
        is_j        = id_valid && (op == OP_J);
        is_jal      = id_valid && (op == OP_JAL);
        is_jr       = id_valid && (op == OP_RTYPE) && (funct == FUNCT_JR);
        jump_target = {pc_hi, instr_addr, 2'b00};
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - front-end redirect/stall sequencer with JR hazard wait and redirect statistics
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int JR_WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [25:0]      InstrAddr,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      rs_data,
    input  logic             jr_hazard,
    input  logic             load_use,
    input  logic             mem_busy,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    output logic [31:0]      npc,
    output logic             redirect,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             link_we,
    output logic             jr_timeout,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int              WAIT_W   = $clog2(JR_WAIT_MAX + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(JR_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(JR_WAIT_MAX);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cnt_inc;
    npc_sel_e          npc_sel;

    logic        is_j, is_jal, is_jr;
    logic [31:0] jump_target;
    logic        unused_pc_low;

    assign unused_pc_low = ^pc_plus4[27:0];

    pc_redirect_decode u_decode (
        .id_valid    (id_valid),
        .op          (Op),
        .funct       (Funct),
        .instr_addr  (InstrAddr),
        .pc_hi       (pc_plus4[31:28]),
        .is_j        (is_j),
        .is_jal      (is_jal),
        .is_jr       (is_jr),
        .jump_target (jump_target)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        cnt_inc    = 1'b0;
        npc_sel    = NPC_NONE;
        redirect   = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        link_we    = 1'b0;

        if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_br_taken) begin
            // A taken branch squashes whatever sits in ID, including a waiting JR.
            npc_sel    = NPC_BRANCH;
            redirect   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_inc    = 1'b1;
            state_d    = ST_RUN;
            wait_cnt_d = '0;
        end else if (state_q == ST_JR_WAIT) begin
            if (jr_hazard) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                if (wait_cnt_q != WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (wait_cnt_q >= WAIT_LIM) begin
                    timeout_d = 1'b1;
                end
            end else begin
                npc_sel    = NPC_RS;
                redirect   = 1'b1;
                ifid_flush = 1'b1;
                cnt_inc    = 1'b1;
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        end else if (is_j || is_jal) begin
            // J/JAL carry no register operand, so a load-use stall never holds them.
            npc_sel    = NPC_JUMP;
            redirect   = 1'b1;
            ifid_flush = 1'b1;
            link_we    = is_jal;
            cnt_inc    = 1'b1;
        end else if (is_jr && jr_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_JR_WAIT;
            wait_cnt_d = WAIT_W'(1);
            if (WAIT_W'(1) > WAIT_LIM) begin
                timeout_d = 1'b1;
            end
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (is_jr) begin
            npc_sel    = NPC_RS;
            redirect   = 1'b1;
            ifid_flush = 1'b1;
            cnt_inc    = 1'b1;
        end

        cnt_d = (cnt_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        case (npc_sel)
            NPC_BRANCH: npc = ex_br_target;
            NPC_JUMP:   npc = jump_target;
            NPC_RS:     npc = rs_data;
            default:    npc = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign jr_timeout   = timeout_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed and randomized self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  Op, Funct;
    logic [25:0] InstrAddr;
    logic [31:0] pc_plus4, rs_data, ex_br_target;
    logic        jr_hazard, load_use, mem_busy, ex_br_taken;
    logic [31:0] npc;
    logic        redirect, pc_we, ifid_we, ifid_flush, idex_flush, link_we, jr_timeout;
    logic [15:0] redirect_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_cnt;

    // expected outputs and next model state
    logic [31:0] e_npc;
    bit e_red, e_pcwe, e_ifwe, e_iff, e_idf, e_link;
    bit n_wait, n_to;
    int n_wcnt, n_cnt;

    pc_redirect_ctrl #(.CNT_W(16), .JR_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Op(Op), .Funct(Funct),
        .InstrAddr(InstrAddr), .pc_plus4(pc_plus4), .rs_data(rs_data),
        .jr_hazard(jr_hazard), .load_use(load_use), .mem_busy(mem_busy),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .npc(npc), .redirect(redirect), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .link_we(link_we),
        .jr_timeout(jr_timeout), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic stall_front(input bit bubble);
        e_pcwe = 0; e_ifwe = 0; e_idf = bubble;
    endtask

    task automatic take(input logic [31:0] tgt);
        e_red = 1; e_npc = tgt; e_iff = 1;
        n_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
    endtask

    // Rules of the controller evaluated against the current inputs.
    task automatic model_eval();
        bit is_j, is_jal, is_jr;
        is_j   = id_valid && Op == 6'd2;
        is_jal = id_valid && Op == 6'd3;
        is_jr  = id_valid && Op == 6'd0 && Funct == 6'd8;
        e_npc = 0; e_red = 0; e_pcwe = 1; e_ifwe = 1; e_iff = 0; e_idf = 0; e_link = 0;
        n_wait = m_wait; n_wcnt = m_wcnt; n_to = m_to; n_cnt = m_cnt;
        if (mem_busy) begin
            stall_front(0);
        end else if (ex_br_taken) begin
            take(ex_br_target); e_idf = 1; n_wait = 0; n_wcnt = 0;
        end else if (m_wait) begin
            if (jr_hazard) begin
                stall_front(1);
                n_wcnt = (m_wcnt + 1 > MAXW + 1) ? MAXW + 1 : m_wcnt + 1;
                if (m_wcnt + 1 > MAXW) n_to = 1;
            end else begin
                take(rs_data); n_wait = 0; n_wcnt = 0;
            end
        end else if (is_j || is_jal) begin
            take({pc_plus4[31:28], InstrAddr, 2'b00}); e_link = is_jal;
        end else if (is_jr && jr_hazard) begin
            stall_front(1); n_wait = 1; n_wcnt = 1;
        end else if (load_use) begin
            stall_front(1);
        end else if (is_jr) begin
            take(rs_data);
        end
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".npc"}, npc, e_npc);
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_red});
        chk({tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, e_pcwe});
        chk({tag, ".ifid_we"}, {31'd0, ifid_we}, {31'd0, e_ifwe});
        chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_iff});
        chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_idf});
        chk({tag, ".link_we"}, {31'd0, link_we}, {31'd0, e_link});
        chk({tag, ".jr_timeout"}, {31'd0, jr_timeout}, {31'd0, m_to});
        chk({tag, ".redirect_cnt"}, {16'd0, redirect_cnt}, m_cnt);
    endtask

    // Check at mid-cycle, clock, advance the model, return at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (rst) begin
            m_wait = n_wait; m_wcnt = n_wcnt; m_to = n_to; m_cnt = n_cnt;
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; Op = 6'h3f; Funct = 0; InstrAddr = 0; pc_plus4 = 0; rs_data = 0;
        jr_hazard = 0; load_use = 0; mem_busy = 0; ex_br_taken = 0; ex_br_target = 0;
    endtask

    task automatic set_jump(input logic [5:0] op);
        id_valid = 1; Op = op; Funct = 0; InstrAddr = 26'h0000100; pc_plus4 = 32'h00400008;
    endtask

    task automatic set_jr(input logic [31:0] rs, input bit hz);
        id_valid = 1; Op = 6'd0; Funct = 6'b001000; rs_data = rs; jr_hazard = hz;
    endtask

    initial begin
        idle();
        rst = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset.redirect", {31'd0, redirect}, 32'd0);
        chk("reset.pc_we", {31'd0, pc_we}, 32'd1);
        chk("reset.npc", npc, 32'd0);
        chk("reset.cnt", {16'd0, redirect_cnt}, 32'd0);
        @(negedge clk);
        rst = 1;
        cycle("idle");

        set_jump(6'b000010);
        #1;
        chk("j.npc_const", npc, 32'h00000400);
        chk("j.cnt_before", {16'd0, redirect_cnt}, 32'd0);
        cycle("j");
        idle();
        #1;
        chk("j.cnt_after", {16'd0, redirect_cnt}, 32'd1);

        set_jump(6'b000011);
        #1;
        chk("jal.link_const", {31'd0, link_we}, 32'd1);
        chk("jal.idex_const", {31'd0, idex_flush}, 32'd0);
        cycle("jal");

        idle();
        set_jr(32'h00400100, 1);
        cycle("jr_hz1");
        cycle("jr_hz2");
        jr_hazard = 0;
        #1;
        chk("jr.npc_const", npc, 32'h00400100);
        chk("jr.redirect_const", {31'd0, redirect}, 32'd1);
        cycle("jr_go");
        idle();
        cycle("after_jr");

        set_jump(6'b000010);
        ex_br_taken = 1; ex_br_target = 32'h00400020;
        #1;
        chk("conflict.npc_const", npc, 32'h00400020);
        cycle("conflict");
        idle();
        cycle("after_conflict");

        set_jump(6'b000010);
        mem_busy = 1;
        #1;
        chk("freeze.redirect_const", {31'd0, redirect}, 32'd0);
        cycle("freeze1");
        cycle("freeze2");
        mem_busy = 0;
        cycle("unfreeze");

        idle();
        set_jump(6'b000010);
        load_use = 1;
        cycle("j_load_use");
        idle();
        set_jr(32'h1234, 0);
        load_use = 1;
        cycle("jr_load_use");

        idle();
        set_jr(32'h00400200, 1);
        for (int i = 0; i < 10; i++) cycle("jr_long");
        #1;
        chk("timeout.sticky_const", {31'd0, jr_timeout}, 32'd1);
        rst = 0;
        #1;
        model_reset();
        chk("rst_mid.timeout", {31'd0, jr_timeout}, 32'd0);
        chk("rst_mid.cnt", {16'd0, redirect_cnt}, 32'd0);
        chk("rst_mid.redirect", {31'd0, redirect}, 32'd0);
        cycle("in_reset");
        rst = 1;
        jr_hazard = 0;
        cycle("jr_after_reset");

        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            id_valid     = ($urandom_range(0, 7) != 0);
            Op           = (r < 3) ? 6'd0 : (r < 5) ? 6'd2 : (r < 7) ? 6'd3 : 6'($urandom);
            Funct        = ($urandom_range(0, 3) != 0) ? 6'd8 : 6'($urandom);
            InstrAddr    = 26'($urandom);
            pc_plus4     = $urandom;
            rs_data      = $urandom;
            jr_hazard    = ($urandom_range(0, 9) < 6);
            load_use     = ($urandom_range(0, 5) == 0);
            mem_busy     = ($urandom_range(0, 7) == 0);
            ex_br_taken  = ($urandom_range(0, 11) == 0);
            ex_br_target = $urandom;
            rst          = ($urandom_range(0, 149) != 0);
            if (!rst) begin
                #1;
                model_reset();
            end
            cycle("rand");
            rst = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
